// File: rtl/display_source_arbiter_pkg.sv
// Shared definitions for the display source arbiter and its neighbours.
// Holds the arbiter state encoding and the default value/dwell sizing that the
// arbiter and numeric_led_display_controller both use, so the two agree.
package display_source_arbiter_pkg;

   // One-bit state encoding: IDLE = 0, DWELL = 1.
   typedef enum logic {
      StIdle  = 1'b0,
      StDwell = 1'b1
   } arb_state_e;

   localparam int unsigned DEF_VALUE_WIDTH = 16;
   localparam int unsigned DEF_DWELL_TICKS = 4;
   localparam int unsigned DEF_DWELL_WIDTH = 3;

endpackage

// File: rtl/display_source_arbiter_rr_pick.sv
// Purely combinational round-robin picker.
// Ports:
//   i_req    - request vector, bit k = source k
//   i_ptr    - index of the last granted source
//   o_valid  - at least one request is set
//   o_winner - first set request found searching upward from i_ptr+1, wrapping
module display_source_arbiter_rr_pick #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned SRC_WIDTH = 2
) (
   input  logic [NUM_SRC-1:0]   i_req,
   input  logic [SRC_WIDTH-1:0] i_ptr,
   output logic                 o_valid,
   output logic [SRC_WIDTH-1:0] o_winner
);

   // Walk offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      o_valid  = 1'b0;
      o_winner = '0;
      for (int unsigned k = NUM_SRC; k >= 1; k--) begin
         idx = (int'(i_ptr) + k) % NUM_SRC;
         if (i_req[idx]) begin
            o_valid  = 1'b1;
            o_winner = SRC_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/display_source_arbiter.sv
// Shares one numeric LED display between NUM_SRC requesters. A round-robin
// winner's value is latched onto o_number_to_display and held for DWELL_TICKS
// i_tick strobes before the next arbitration.
// Ports:
//   i_clk, i_reset_n     - clock, synchronous active-low reset
//   i_tick               - one-cycle dwell time-base strobe
//   i_req, i_value       - per-source level request and packed values
//   o_ack                - one-hot one-cycle pulse: that source's value latched
//   o_number_to_display  - registered value for the display controller
//   o_active_src         - index of the last granted source
//   o_busy               - high while dwelling
// Build option: define DISPLAY_ARB_PREEMPT_EN to let source 0 preempt a dwell
// held by any other source.
module display_source_arbiter
   import display_source_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned SRC_WIDTH   = 2,
   parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH,
   parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS,
   parameter int unsigned DWELL_WIDTH = DEF_DWELL_WIDTH
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic                           i_tick,
   input  logic [NUM_SRC-1:0]             i_req,
   input  logic [NUM_SRC*VALUE_WIDTH-1:0] i_value,
   output logic [NUM_SRC-1:0]             o_ack,
   output logic [VALUE_WIDTH-1:0]         o_number_to_display,
   output logic [SRC_WIDTH-1:0]           o_active_src,
   output logic                           o_busy
);

   arb_state_e             state_q, state_d;
   logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
   logic [SRC_WIDTH-1:0]   ptr_q, ptr_d;
   logic [SRC_WIDTH-1:0]   active_q, active_d;
   logic [VALUE_WIDTH-1:0] disp_q, disp_d;
   logic [NUM_SRC-1:0]     ack_q, ack_d;

   logic                   pick_valid;
   logic [SRC_WIDTH-1:0]   pick_winner;
   logic                   preempt;
   logic                   grant;
   logic [SRC_WIDTH-1:0]   winner;

   display_source_arbiter_rr_pick #(
      .NUM_SRC   (NUM_SRC),
      .SRC_WIDTH (SRC_WIDTH)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (ptr_q),
      .o_valid  (pick_valid),
      .o_winner (pick_winner)
   );

`ifdef DISPLAY_ARB_PREEMPT_EN
   // Source 0 is urgent, but never preempts its own dwell.
   assign preempt = (state_q == StDwell) && i_req[0] && (active_q != '0);
`else
   assign preempt = 1'b0;
`endif

   assign grant  = ((state_q == StIdle) && pick_valid) || preempt;
   assign winner = preempt ? '0 : pick_winner;

   // State register and all datapath flops.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ptr_q    <= SRC_WIDTH'(NUM_SRC - 1);
         active_q <= '0;
         disp_q   <= '0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         active_q <= active_d;
         disp_q   <= disp_d;
         ack_q    <= ack_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant) state_d = StDwell;
         StDwell: if (!preempt && i_tick && (cnt_q == DWELL_WIDTH'(1))) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output / datapath next values. A tick on the grant edge is ignored because
   // the load of DWELL_TICKS takes priority over the decrement.
   always_comb begin
      ack_d    = '0;
      disp_d   = disp_q;
      active_d = active_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      if (grant) begin
         ack_d[winner] = 1'b1;
         disp_d        = i_value[int'(winner)*VALUE_WIDTH +: VALUE_WIDTH];
         active_d      = winner;
         ptr_d         = winner;
         cnt_d         = DWELL_WIDTH'(DWELL_TICKS);
      end else if ((state_q == StDwell) && i_tick) begin
         cnt_d = cnt_q - DWELL_WIDTH'(1);
      end
   end

   assign o_ack               = ack_q;
   assign o_number_to_display = disp_q;
   assign o_active_src        = active_q;
   assign o_busy              = (state_q == StDwell);

endmodule

// File: tb/tb_display_source_arbiter.sv
module tb_display_source_arbiter;

   localparam int N  = 4;
   localparam int VW = 16;
   localparam int DT = 4;
`ifdef DISPLAY_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            tick;
   logic [N-1:0]    req;
   logic [N*VW-1:0] value;
   logic [N-1:0]    o_ack;
   logic [VW-1:0]   o_disp;
   logic [1:0]      o_active;
   logic            o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: dwell as "ticks remaining", pointer as a plain integer.
   int           m_ptr, m_active, m_rem;
   bit           m_busy;
   logic [VW-1:0] m_disp;
   logic [N-1:0]  m_ack;

   always #5 clk = ~clk;

   display_source_arbiter u_dut (
      .i_clk               (clk),
      .i_reset_n           (rst_n),
      .i_tick              (tick),
      .i_req               (req),
      .i_value             (value),
      .o_ack               (o_ack),
      .o_number_to_display (o_disp),
      .o_active_src        (o_active),
      .o_busy              (o_busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void model_edge();
      int  w;
      bit  pre;
      m_ack = '0;
      if (!rst_n) begin
         m_busy = 0; m_rem = 0; m_ptr = N - 1; m_active = 0; m_disp = '0;
         return;
      end
      pre = PREEMPT && m_busy && req[0] && (m_active != 0);
      w   = -1;
      if (pre) w = 0;
      else if (!m_busy) begin
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
         m_ack[w] = 1'b1;
         m_disp   = value[w*VW +: VW];
         m_active = w;
         m_ptr    = w;
         m_rem    = DT;
         m_busy   = 1;
      end else if (m_busy && tick) begin
         m_rem--;
         if (m_rem == 0) m_busy = 0;
      end
   endfunction

   task automatic step(input bit r, input logic [N-1:0] q, input bit t);
      rst_n = r; req = q; tick = t;
      @(posedge clk);
      model_edge();
      #1;
      check("ack", o_ack, m_ack);
      check("display", o_disp, m_disp);
      check("active_src", o_active, m_active);
      check("busy", o_busy, m_busy);
      check("ack_onehot0", $onehot0(o_ack), 1);
   endtask

   initial begin
      int order[$];
      int last;
      rst_n = 0; req = '0; tick = 0; value = '0;
      m_ptr = N - 1; m_active = 0; m_rem = 0; m_busy = 0; m_disp = '0; m_ack = '0;

      // Reset state
      step(0, 4'b0000, 0);
      step(0, 4'b1111, 1);
      check("rst_disp", o_disp, 0);
      check("rst_busy", o_busy, 0);

      // Single request, then dwell of 4 ticks
      value[15:0] = 16'h1234;
      step(1, 4'b0001, 0);
      check("t1_ack", o_ack, 4'b0001);
      check("t1_disp", o_disp, 16'h1234);
      check("t1_busy", o_busy, 1);
      for (int i = 0; i < 3; i++) step(1, 4'b0000, 1);
      check("t1_busy_3ticks", o_busy, 1);
      step(1, 4'b0000, 1);
      check("t1_idle_4ticks", o_busy, 0);

      // All requesting: round-robin order and 5-cycle spacing with tick every cycle
      step(0, 4'b0000, 0);
      value = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
      last = -1;
      for (int c = 0; c < 30; c++) begin
         step(1, 4'b1111, 1);
         if (o_ack != '0) begin
            order.push_back($clog2(o_ack));
            if (last >= 0) check("t2_gap", c - last, 5);
            last = c;
         end
      end
      check("t2_grant_count", order.size(), 6);
      for (int i = 0; i < 5 && i < order.size(); i++) check("t2_order", order[i], i % 4);

      // Source 2 waits for source 1's dwell to expire
      step(0, 4'b0000, 0);
      step(1, 4'b0010, 0);
      check("t3_ack1", o_ack, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         step(1, 4'b0100, 1);
         check("t3_no_ack", o_ack, 4'b0000);
      end
      step(1, 4'b0100, 0);
      check("t3_ack2", o_ack, 4'b0100);
      check("t3_disp", o_disp, 16'h00A2);

      // Tick on the grant edge is ignored
      step(0, 4'b0000, 0);
      step(1, 4'b0001, 1);
      for (int i = 0; i < 3; i++) step(1, 4'b0000, 1);
      check("t4_busy_after3", o_busy, 1);
      step(1, 4'b0000, 1);
      check("t4_idle_after4", o_busy, 0);

      // Reset mid-dwell
      value[15:0] = 16'hBEEF;
      step(1, 4'b0001, 0);
      check("t5_disp", o_disp, 16'hBEEF);
      step(1, 4'b0000, 1);
      step(0, 4'b1111, 1);
      check("t5_rst_disp", o_disp, 0);
      check("t5_rst_busy", o_busy, 0);
      check("t5_rst_active", o_active, 0);
      step(1, 4'b1111, 0);
      check("t5_first_after_rst", o_ack, 4'b0001);

      // Source 0 during source 3 dwell
      step(0, 4'b0000, 0);
      step(1, 4'b1000, 0);
      check("t6_ack3", o_ack, 4'b1000);
      step(1, 4'b0001, 0);
      check("t6_preempt_ack", o_ack, PREEMPT ? 4'b0001 : 4'b0000);
      check("t6_active", o_active, PREEMPT ? 0 : 3);

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         value = {$urandom, $urandom};
         step(($urandom_range(63) != 0), 4'($urandom), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
